botao_pedestre_cond: RTL and testbench
======================================

Name: botao_pedestre_cond

Overview:
Conditioning stage directly upstream of semaforo_pedestre. It takes the raw, asynchronous, bouncing pedestrian push-button and produces a clean single-cycle `botao_pedestre` request pulse. It also enforces a post-request lockout and keeps a "pedido pendente" (wait) lamp lit until the light controller acknowledges the crossing phase. A saturating count of accepted requests is provided for debug and statistics.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on botao_raw (minimum 2).
DEBOUNCE_CYCLES, 4, consecutive cycles a changed level must hold before it is accepted (minimum 1).
LOCKOUT_CYCLES, 20, cycles after an emitted pulse during which new presses are ignored (minimum 1).
CNT_W, 8, width of the accepted-request counter.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst  in  1  asynchronous, active-high reset.
botao_raw  in  1  raw push-button level; asynchronous and may bounce.
ack_pedestre  in  1  level/pulse from the light controller when the pedestrian phase starts; clears the pending lamp.
botao_pedestre  out  1  clean one-cycle request pulse; connects to semaforo_pedestre.botao_pedestre.
pedido_pendente  out  1  wait lamp: set by an accepted request, cleared by ack_pedestre.
bloqueio  out  1  high while in the lockout window.
total_pedidos  out  CNT_W  saturating count of accepted requests.

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - Synchronizer flops, debounced level, delayed level, debounce counter and lockout counter all reset to 0.
  - FSM resets to IDLE.
  - botao_pedestre=0, pedido_pendente=0, bloqueio=0, total_pedidos=0.
  - Outputs drop in the same instant rst rises, including mid-pulse and mid-lockout.
- Synchronizer: SYNC_STAGES-flop shift chain; sync_out is the last stage.
- Debounce:
  - Counter increments on each edge where sync_out != stable.
  - Counter clears on any edge where sync_out == stable.
  - On the DEBOUNCE_CYCLES-th consecutive differing edge, stable takes sync_out and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES is therefore discarded.
- Press event: stable & ~stable_d, where stable_d is stable delayed one cycle. This is edge-based, so holding the button never retriggers.
- FSM, 3 states:
  - IDLE: press event -> EMITE; otherwise stay.
  - EMITE: lasts exactly one cycle; botao_pedestre=1 (Moore output); lockout counter loaded with LOCKOUT_CYCLES-1; -> BLOQUEIO.
  - BLOQUEIO: bloqueio=1; counter decrements each cycle; at 0 -> IDLE. Total time in BLOQUEIO is LOCKOUT_CYCLES cycles.
  - Press events in EMITE or BLOQUEIO are dropped, not queued. A still-held button does not fire on return to IDLE; a new release-and-press is required.
- Latency: if botao_raw goes high before edge 1 and stays high, botao_pedestre is high in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES+1. With defaults that is after edge 7.
- pedido_pendente:
  - Set on entry to EMITE.
  - Cleared on any edge with ack_pedestre=1 and no simultaneous EMITE entry.
  - If EMITE entry and ack occur on the same edge, the set wins.
  - ack while already 0 has no effect.
- total_pedidos: increments on entry to EMITE and saturates at 2^CNT_W-1 with no wrap.
- Release path: the falling edge of stable produces no output and does not affect the FSM.

Decomposition:
- Shared package semaforo_pkg holds:
  - typedef enum logic [1:0] {IDLE, EMITE, BLOQUEIO} botao_estado_t
  - Default constants DEBOUNCE_CYCLES_DEF and LOCKOUT_CYCLES_DEF.
- One natural sub-module, debounce_sync: synchronizer plus debounce counter, outputs stable. Parameters: SYNC_STAGES, DEBOUNCE_CYCLES.
- The FSM, lamp and counter stay in the top module.

Test Plan:
1. Reset with default parameters -> all outputs 0. Then hold botao_raw=1 from before edge 1 -> botao_pedestre=1 only in the cycle after edge 7; pedido_pendente=1 and total_pedidos=1 from then on; bloqueio=1 for the following 20 cycles.
2. Bounce: raw toggles 1,0,1,0 on single cycles, then stays 0 -> botao_pedestre never asserts and total_pedidos stays 0. A 3-cycle high pulse (below DEBOUNCE_CYCLES=4) also gives no output.
3. Lockout: press accepted, release, press again at cycle 10 of BLOQUEIO -> no second pulse and total_pedidos=1. Release and re-press after bloqueio falls -> second pulse and total_pedidos=2.
4. Held button: keep raw=1 for 100 cycles -> exactly one pulse.
5. Lamp: pulse sets pedido_pendente; ack_pedestre=1 for one cycle 15 cycles later clears it on that edge. Ack coincident with EMITE entry -> pedido_pendente stays 1.
6. Reset mid-lockout and saturation: assert rst at lockout cycle 5 -> bloqueio, pedido_pendente and total_pedidos go to 0 immediately. With CNT_W=2 and 5 accepted presses -> total_pedidos=3.

Source files
------------

// File: rtl/semaforo_pkg.sv
// Shared types and default constants for the pedestrian crossing blocks.
// The button conditioner and the light controller both import this package.
package semaforo_pkg;

  typedef enum logic [1:0] {IDLE, EMITE, BLOQUEIO} botao_estado_t;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int LOCKOUT_CYCLES_DEF  = 20;
  localparam int CNT_W_DEF           = 8;

endpackage

// File: rtl/debounce_sync.sv
// Brings the raw asynchronous button into the clk domain and debounces it.
// A level change is accepted only after DEBOUNCE_CYCLES consecutive differing cycles.
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic botao_raw,
  output logic stable
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [DW-1:0]          deb_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], botao_raw};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Debounce: any cycle agreeing with the accepted level restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
      stable  <= 1'b0;
    end else if (sync_out == stable) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      stable  <= sync_out;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/botao_pedestre_cond.sv
// Pedestrian button conditioner: clean one-cycle request pulse, lockout window,
// pending-request lamp and a saturating accepted-request counter.
module botao_pedestre_cond
  import semaforo_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             botao_raw,
  input  logic             ack_pedestre,
  output logic             botao_pedestre,
  output logic             pedido_pendente,
  output logic             bloqueio,
  output logic [CNT_W-1:0] total_pedidos
);

  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic          stable;
  logic          stable_d;
  logic          press;
  logic          entra_emite;
  logic [LW-1:0] lock_cnt;
  botao_estado_t estado, prox_estado;

  debounce_sync #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .botao_raw (botao_raw),
    .stable    (stable)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d <= 1'b0;
    end else begin
      stable_d <= stable;
    end
  end

  // Rising edge only: a held button or a release never creates a request
  assign press       = stable & ~stable_d;
  assign entra_emite = (estado == IDLE) && press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= IDLE;
    end else begin
      estado <= prox_estado;
    end
  end

  always_comb begin
    prox_estado = estado;
    unique case (estado)
      IDLE:     prox_estado = press ? EMITE : IDLE;
      EMITE:    prox_estado = BLOQUEIO;
      BLOQUEIO: prox_estado = (lock_cnt == '0) ? IDLE : BLOQUEIO;
      default:  prox_estado = IDLE;
    endcase
  end

  always_comb begin
    botao_pedestre = (estado == EMITE);
    bloqueio       = (estado == BLOQUEIO);
  end

  // Loaded during EMITE so that BLOQUEIO spans exactly LOCKOUT_CYCLES cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
    end else if (estado == EMITE) begin
      lock_cnt <= LW'(LOCKOUT_CYCLES - 1);
    end else if ((estado == BLOQUEIO) && (lock_cnt != '0)) begin
      lock_cnt <= lock_cnt - 1'b1;
    end
  end

  // A new request on the same edge as an ack keeps the lamp lit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pedido_pendente <= 1'b0;
    end else if (entra_emite) begin
      pedido_pendente <= 1'b1;
    end else if (ack_pedestre) begin
      pedido_pendente <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_pedidos <= '0;
    end else if (entra_emite) begin
      total_pedidos <= sat_inc(total_pedidos);
    end
  end

endmodule

// File: tb/tb_botao_pedestre_cond.sv
// Randomized and directed bench for botao_pedestre_cond with an edge-count reference model.
module tb_botao_pedestre_cond;

  localparam int S = 2;
  localparam int D = 4;
  localparam int L = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       botao_raw = 1'b0;
  logic       ack_pedestre = 1'b0;
  logic       botao_pedestre, pedido_pendente, bloqueio;
  logic [7:0] total_pedidos;
  logic       botao_pedestre2, pedido_pendente2, bloqueio2;
  logic [1:0] total_pedidos2;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int bloq_cnt = 0;

  always #5 clk = ~clk;

  botao_pedestre_cond #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .botao_raw(botao_raw), .ack_pedestre(ack_pedestre),
    .botao_pedestre(botao_pedestre), .pedido_pendente(pedido_pendente),
    .bloqueio(bloqueio), .total_pedidos(total_pedidos));

  botao_pedestre_cond #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .botao_raw(botao_raw), .ack_pedestre(ack_pedestre),
    .botao_pedestre(botao_pedestre2), .pedido_pendente(pedido_pendente2),
    .bloqueio(bloqueio2), .total_pedidos(total_pedidos2));

  // Reference model: edge-numbered view of the expected behaviour
  int m_n = 0, m_last_e = -1000, m_free = 0, m_run = 0, m_cnt = 0;
  bit m_st = 0, m_st_prev = 0, m_pend = 0;
  bit sq[$];
  bit e_pulse = 0, e_bloq = 0, e_pend = 0;
  int e_tot = 0, e_tot2 = 0;

  initial begin
    for (int i = 0; i < S; i++) sq.push_back(1'b0);
    forever begin : model
      bit syncv, pr;
      @(posedge clk or posedge rst);
      if (rst) begin
        m_n = 0; m_last_e = -1000; m_free = 0; m_run = 0; m_cnt = 0;
        m_st = 0; m_st_prev = 0; m_pend = 0;
        sq = {};
        for (int i = 0; i < S; i++) sq.push_back(1'b0);
      end else begin
        m_n++;
        syncv = sq.pop_front();
        sq.push_back(botao_raw);
        pr = m_st && !m_st_prev;
        m_st_prev = m_st;
        if (syncv != m_st) begin
          m_run++;
          if (m_run == D) begin
            m_st = syncv;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
        if (pr && m_n >= m_free) begin
          m_last_e = m_n;
          m_free = m_n + L + 2;
          m_cnt++;
          m_pend = 1;
        end else if (ack_pedestre) begin
          m_pend = 0;
        end
      end
      e_pulse = (m_last_e == m_n);
      e_bloq  = (m_n > m_last_e) && (m_n <= m_last_e + L);
      e_pend  = m_pend;
      e_tot   = (m_cnt > 255) ? 255 : m_cnt;
      e_tot2  = (m_cnt > 3) ? 3 : m_cnt;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d edge=%0d t=%0t", nm, act, exp, m_n, $time);
    end
  endtask

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_botao_pedestre", int'(botao_pedestre), int'(e_pulse));
      check("cyc_bloqueio", int'(bloqueio), int'(e_bloq));
      check("cyc_pedido_pendente", int'(pedido_pendente), int'(e_pend));
      check("cyc_total_pedidos", int'(total_pedidos), e_tot);
      check("cyc_total_pedidos_cnt2", int'(total_pedidos2), e_tot2);
      if (botao_pedestre) pulse_cnt++;
      if (bloqueio) bloq_cnt++;
    end
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    step(3);
    check("reset_botao", int'(botao_pedestre), 0);
    check("reset_bloqueio", int'(bloqueio), 0);
    check("reset_pendente", int'(pedido_pendente), 0);
    check("reset_total", int'(total_pedidos), 0);

    // First press held from before edge 1, kept for 100 cycles
    rst = 1'b0;
    botao_raw = 1'b1;
    pulse_cnt = 0;
    bloq_cnt = 0;
    step(6);
    check("latency_no_early_pulse", int'(botao_pedestre), 0);
    step(1);
    check("latency_pulse_edge7", int'(botao_pedestre), 1);
    check("model_pulse_edge7", int'(e_pulse), 1);
    check("first_pendente", int'(pedido_pendente), 1);
    check("first_total", int'(total_pedidos), 1);
    step(1);
    check("pulse_one_cycle", int'(botao_pedestre), 0);
    check("bloqueio_starts", int'(bloqueio), 1);
    step(92);
    check("held_single_pulse", pulse_cnt, 1);
    check("bloqueio_length", bloq_cnt, L);
    check("held_total", int'(total_pedidos), 1);

    ack_pedestre = 1'b1;
    step(1);
    check("ack_clears_lamp", int'(pedido_pendente), 0);
    ack_pedestre = 1'b0;
    botao_raw = 1'b0;
    step(12);

    // Bounce and short pulse rejection
    botao_raw = 1'b1; step(1);
    botao_raw = 1'b0; step(1);
    botao_raw = 1'b1; step(1);
    botao_raw = 1'b0; step(12);
    botao_raw = 1'b1; step(3);
    botao_raw = 1'b0; step(12);
    check("bounce_no_pulse", pulse_cnt, 1);
    check("bounce_total", int'(total_pedidos), 1);

    // Lockout: re-press inside BLOQUEIO is dropped
    botao_raw = 1'b1; step(7);
    check("lockout_first_pulse", int'(botao_pedestre), 1);
    check("lockout_first_total", int'(total_pedidos), 2);
    botao_raw = 1'b0; step(5);
    botao_raw = 1'b1; step(9);
    ack_pedestre = 1'b1; step(1);
    check("ack_15_later_clears", int'(pedido_pendente), 0);
    ack_pedestre = 1'b0;
    step(10);
    check("lockout_dropped_total", int'(total_pedidos), 2);
    check("lockout_dropped_pulses", pulse_cnt, 2);
    botao_raw = 1'b0; step(10);
    botao_raw = 1'b1; step(7);
    check("after_lockout_pulse", int'(botao_pedestre), 1);
    check("after_lockout_total", int'(total_pedidos), 3);
    botao_raw = 1'b0; step(30);

    // Ack coincident with EMITE entry
    botao_raw = 1'b1; step(6);
    ack_pedestre = 1'b1; step(1);
    check("coincident_pulse", int'(botao_pedestre), 1);
    check("coincident_set_wins", int'(pedido_pendente), 1);
    ack_pedestre = 1'b0;
    botao_raw = 1'b0; step(30);

    // Fifth request saturates the 2-bit counter
    botao_raw = 1'b1; step(7);
    check("sat_total_cnt8", int'(total_pedidos), 5);
    check("sat_total_cnt2", int'(total_pedidos2), 3);
    botao_raw = 1'b0; step(30);

    // Random presses, bounces and acks
    repeat (200) begin
      botao_raw = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) begin
        ack_pedestre = ($urandom_range(0, 7) == 0);
        step(1);
      end
    end
    ack_pedestre = 1'b0;
    botao_raw = 1'b0; step(40);

    // Reset in the middle of the lockout window
    botao_raw = 1'b1; step(7);
    check("midreset_pulse", int'(botao_pedestre), 1);
    step(5);
    check("midreset_in_lockout", int'(bloqueio), 1);
    check("midreset_lamp_on", int'(pedido_pendente), 1);
    rst = 1'b1;
    #1;
    check("midreset_bloqueio", int'(bloqueio), 0);
    check("midreset_pendente", int'(pedido_pendente), 0);
    check("midreset_total", int'(total_pedidos), 0);
    check("midreset_total_cnt2", int'(total_pedidos2), 0);
    check("midreset_botao", int'(botao_pedestre), 0);
    step(3);
    rst = 1'b0;
    botao_raw = 1'b0;
    step(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
